// File: rtl/logic_healthcare_system_controller_pkg.sv
// Shared types for the patient-monitoring alarm controller.
//   warn_e     : 3-bit warning code, ordered by ascending severity so that
//                numeric comparison equals severity comparison.
//   NERV_*     : encodings of the 2-bit nervous-system severity input.
package healthcare_pkg;

    typedef enum logic [2:0] {
        NORMAL           = 3'd0,
        TEMPERATURE      = 3'd1,
        BLOOD            = 3'd2,
        PRESSURE         = 3'd3,
        NERVOUS_MILD     = 3'd4,
        NERVOUS_SEVERE   = 3'd5,
        NERVOUS_CRITICAL = 3'd6,
        FALL             = 3'd7
    } warn_e;

    localparam logic [1:0] NERV_NONE     = 2'b00;
    localparam logic [1:0] NERV_MILD     = 2'b01;
    localparam logic [1:0] NERV_SEVERE   = 2'b10;
    localparam logic [1:0] NERV_CRITICAL = 2'b11;

endpackage

// File: rtl/logic_healthcare_system_controller_if.sv
// Sensor-flag / warning bundle between the sensor front-ends and the
// alarm controller.
//   master : sensor side, drives the abnormality flags, reads the warning.
//   slave  : controller side, reads the flags, drives the warning.
interface logic_healthcare_system_controller_if;

    logic       presureAbnormality;
    logic       bloodAbnormality;
    logic       fallDetected;
    logic       temperatureAbnormality;
    logic [1:0] nervousAbnormality;
    logic [2:0] abnormalityWarning;

    modport master (
        output presureAbnormality,
        output bloodAbnormality,
        output fallDetected,
        output temperatureAbnormality,
        output nervousAbnormality,
        input  abnormalityWarning
    );

    modport slave (
        input  presureAbnormality,
        input  bloodAbnormality,
        input  fallDetected,
        input  temperatureAbnormality,
        input  nervousAbnormality,
        output abnormalityWarning
    );

endinterface

// File: rtl/logic_healthcare_system_controller_encoder.sv
// Purely combinational priority encoder: abnormality flags -> requested
// warning level (highest active severity wins, NORMAL when none active).
//   fall, pressure, blood, temperature : 1-bit flags
//   nervous                            : 2-bit severity
//   reqLevel                           : requested warning level
module abnormality_priority_encoder
    import healthcare_pkg::*;
(
    input  logic       fall,
    input  logic       pressure,
    input  logic       blood,
    input  logic       temperature,
    input  logic [1:0] nervous,
    output warn_e      reqLevel
);

    always_comb begin
        reqLevel = NORMAL;
        if (fall)                          reqLevel = FALL;
        else if (nervous == NERV_CRITICAL) reqLevel = NERVOUS_CRITICAL;
        else if (nervous == NERV_SEVERE)   reqLevel = NERVOUS_SEVERE;
        else if (nervous == NERV_MILD)     reqLevel = NERVOUS_MILD;
        else if (pressure)                 reqLevel = PRESSURE;
        else if (blood)                    reqLevel = BLOOD;
        else if (temperature)              reqLevel = TEMPERATURE;
    end

endmodule

// File: rtl/logic_healthcare_system_controller.sv
// Patient-monitoring alarm controller. Escalates to a higher requested
// warning on the next edge; de-escalates only after a lower request has
// persisted for HOLD_CYCLES consecutive edges, then jumps straight to the
// request sampled at the expiring edge.
//   clock  : rising-edge system clock
//   resetN : asynchronous active-low reset
//   bus    : flags in, registered warning code out (Moore output)
module logic_healthcare_system_controller
    import healthcare_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4   // 1..255
) (
    input  logic clock,
    input  logic resetN,
    logic_healthcare_system_controller_if.slave bus
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    warn_e      reqLevel;
    warn_e      state, stateNext;
    logic [7:0] holdCnt, holdCntNext;

    abnormality_priority_encoder encoder (
        .fall        (bus.fallDetected),
        .pressure    (bus.presureAbnormality),
        .blood       (bus.bloodAbnormality),
        .temperature (bus.temperatureAbnormality),
        .nervous     (bus.nervousAbnormality),
        .reqLevel    (reqLevel)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state   <= NORMAL;
            holdCnt <= 8'd0;
        end else begin
            state   <= stateNext;
            holdCnt <= holdCntNext;
        end
    end

    // Counter only advances while a lower request persists; any edge with
    // req >= state (or the expiring edge itself) clears it.
    always_comb begin
        stateNext   = state;
        holdCntNext = 8'd0;
        if (reqLevel > state) begin
            stateNext = reqLevel;
        end else if (reqLevel < state) begin
            if (holdCnt == HOLD_LAST) stateNext   = reqLevel;
            else                      holdCntNext = holdCnt + 8'd1;
        end
    end

    assign bus.abnormalityWarning = state;

endmodule

// File: tb/tb_logic_healthcare_system_controller.sv
module tb_logic_healthcare_system_controller;

    logic clock;
    logic resetN;
    int   total = 0;
    int   bad   = 0;

    logic_healthcare_system_controller_if if1 ();
    logic_healthcare_system_controller_if if4 ();

    logic_healthcare_system_controller #(.HOLD_CYCLES(1)) dut1 (
        .clock (clock), .resetN (resetN), .bus (if1)
    );
    logic_healthcare_system_controller #(.HOLD_CYCLES(4)) dut4 (
        .clock (clock), .resetN (resetN), .bus (if4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic setFlags(input logic fall, input logic pr, input logic bl,
                            input logic tp, input logic [1:0] nv);
        if1.fallDetected = fall; if1.presureAbnormality = pr;
        if1.bloodAbnormality = bl; if1.temperatureAbnormality = tp;
        if1.nervousAbnormality = nv;
        if4.fallDetected = fall; if4.presureAbnormality = pr;
        if4.bloodAbnormality = bl; if4.temperatureAbnormality = tp;
        if4.nervousAbnormality = nv;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        resetN = 1'b0;
        setFlags(0, 0, 0, 0, 2'b00);
        step(); step();
        chk("rst_d1", if1.abnormalityWarning, 3'b000);
        chk("rst_d4", if4.abnormalityWarning, 3'b000);

        // reset dominates with every flag active
        setFlags(1, 1, 1, 1, 2'b11);
        step();
        chk("rst_allflags", if4.abnormalityWarning, 3'b000);
        resetN = 1'b1;
        step();
        chk("rel_d1", if1.abnormalityWarning, 3'b111);
        chk("rel_d4", if4.abnormalityWarning, 3'b111);

        // asynchronous assertion, mid-cycle
        #2 resetN = 1'b0;
        #1;
        chk("async_d1", if1.abnormalityWarning, 3'b000);
        chk("async_d4", if4.abnormalityWarning, 3'b000);
        step();
        resetN = 1'b1;
        setFlags(0, 0, 0, 0, 2'b00);
        step();
        chk("idle", if4.abnormalityWarning, 3'b000);

        // priority ladder (escalation, both instances)
        setFlags(0, 0, 0, 1, 2'b00); step(); chk("lad_temp",  if1.abnormalityWarning, 3'b001);
        setFlags(0, 0, 1, 0, 2'b00); step(); chk("lad_blood", if1.abnormalityWarning, 3'b010);
        setFlags(0, 1, 0, 0, 2'b00); step(); chk("lad_press", if1.abnormalityWarning, 3'b011);
        setFlags(0, 0, 0, 0, 2'b01); step(); chk("lad_nmild", if1.abnormalityWarning, 3'b100);
        setFlags(0, 0, 0, 0, 2'b10); step(); chk("lad_nsev",  if1.abnormalityWarning, 3'b101);
        setFlags(0, 0, 0, 0, 2'b11); step(); chk("lad_ncrit", if1.abnormalityWarning, 3'b110);
        chk("lad_ncrit_d4", if4.abnormalityWarning, 3'b110);
        setFlags(1, 0, 0, 0, 2'b00); step(); chk("lad_fall",  if1.abnormalityWarning, 3'b111);
        setFlags(0, 1, 1, 1, 2'b00); step();
        chk("combo_d1", if1.abnormalityWarning, 3'b011);
        chk("combo_d4_hold", if4.abnormalityWarning, 3'b111);

        // escalation then delayed de-escalation (HOLD_CYCLES=4)
        setFlags(1, 1, 1, 1, 2'b00); step();
        chk("esc_all", if4.abnormalityWarning, 3'b111);
        setFlags(0, 1, 1, 1, 2'b11);
        step(); chk("deesc_e1", if4.abnormalityWarning, 3'b111);
        chk("deesc_e1_d1", if1.abnormalityWarning, 3'b110);
        step(); chk("deesc_e2", if4.abnormalityWarning, 3'b111);
        step(); chk("deesc_e3", if4.abnormalityWarning, 3'b111);
        step(); chk("deesc_e4", if4.abnormalityWarning, 3'b110);

        // hold abort
        setFlags(1, 1, 1, 1, 2'b00); step(); chk("abort_up", if4.abnormalityWarning, 3'b111);
        setFlags(0, 1, 1, 1, 2'b00);
        step(); chk("abort_h1", if4.abnormalityWarning, 3'b111);
        step(); chk("abort_h2", if4.abnormalityWarning, 3'b111);
        setFlags(1, 1, 1, 1, 2'b00);
        step(); chk("abort_re", if4.abnormalityWarning, 3'b111);
        setFlags(0, 1, 1, 1, 2'b00);
        step(); chk("abort_d1", if4.abnormalityWarning, 3'b111);
        step(); chk("abort_d2", if4.abnormalityWarning, 3'b111);
        step(); chk("abort_d3", if4.abnormalityWarning, 3'b111);
        step(); chk("abort_d4", if4.abnormalityWarning, 3'b011);

        // mixed lower targets from 110
        setFlags(0, 1, 1, 1, 2'b11); step(); chk("mix_up", if4.abnormalityWarning, 3'b110);
        setFlags(0, 0, 0, 1, 2'b00); step();
        chk("mix_e1", if4.abnormalityWarning, 3'b110); chk("mix_e1_d1", if1.abnormalityWarning, 3'b001);
        setFlags(0, 0, 1, 0, 2'b00); step();
        chk("mix_e2", if4.abnormalityWarning, 3'b110); chk("mix_e2_d1", if1.abnormalityWarning, 3'b010);
        setFlags(0, 1, 0, 0, 2'b00); step();
        chk("mix_e3", if4.abnormalityWarning, 3'b110); chk("mix_e3_d1", if1.abnormalityWarning, 3'b011);
        setFlags(0, 0, 1, 0, 2'b00); step();
        chk("mix_e4", if4.abnormalityWarning, 3'b010); chk("mix_e4_d1", if1.abnormalityWarning, 3'b010);

        // reset mid-hold
        setFlags(1, 0, 0, 0, 2'b00); step(); chk("mh_up", if4.abnormalityWarning, 3'b111);
        setFlags(0, 0, 0, 0, 2'b00);
        step(); step();
        chk("mh_held", if4.abnormalityWarning, 3'b111);
        #2 resetN = 1'b0;
        #1 chk("mh_rst", if4.abnormalityWarning, 3'b000);
        step();
        resetN = 1'b1;
        setFlags(1, 0, 0, 0, 2'b00); step(); chk("mh_up2", if4.abnormalityWarning, 3'b111);
        setFlags(0, 0, 0, 0, 2'b00);
        step(); chk("mh_h1", if4.abnormalityWarning, 3'b111);
        step(); chk("mh_h2", if4.abnormalityWarning, 3'b111);
        step(); chk("mh_h3", if4.abnormalityWarning, 3'b111);
        step(); chk("mh_h4", if4.abnormalityWarning, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_healthcare_system_controller.md
Name: logic_healthcare_system_controller

Overview:
- Patient-monitoring alarm controller. Sensor front-ends drive abnormality flags in; the block drives a 3-bit registered warning code to the display/alarm logic.
- The abnormality flags are priority-encoded into a requested warning level.
- A Moore FSM tracks the current level. It escalates on the next clock edge and de-escalates only after the lower request persists for HOLD_CYCLES cycles.

Parameters:
- HOLD_CYCLES, default 4: consecutive cycles a lower request must persist before de-escalation. Legal range 1..255; 1 means immediate de-escalation.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetN  in  1  asynchronous, active-low reset.
- presureAbnormality  in  1  blood-pressure abnormal flag.
- bloodAbnormality  in  1  blood-chemistry abnormal flag.
- fallDetected  in  1  patient fall detected.
- temperatureAbnormality  in  1  temperature abnormal flag.
- nervousAbnormality  in  2  nervous-system severity: 00 none, 01 mild, 10 severe, 11 critical.
- abnormalityWarning  out  3  current warning code; registered state, Moore output.

Behaviour:
- Inputs are sampled on the rising edge of clock. They are assumed synchronous to clock; no synchronizers inside.
- Warning codes, in ascending severity:
  - 000 NORMAL
  - 001 TEMPERATURE
  - 010 BLOOD
  - 011 PRESSURE
  - 100 NERVOUS_MILD
  - 101 NERVOUS_SEVERE
  - 110 NERVOUS_CRITICAL
  - 111 FALL
- Requested level (combinational) = the highest code among active conditions. With no condition active it is NORMAL.
- State register holds the current level. abnormalityWarning equals the state directly, with no combinational path from inputs.
- Hold counter: 8 bits wide.
- Transitions at each rising edge (req = requested level, cur = state):
  - req > cur: state <= req, counter <= 0. Latency: 1 edge.
  - req == cur: state holds, counter <= 0.
  - req < cur and counter == HOLD_CYCLES-1: state <= req (jump directly, no stepping), counter <= 0.
  - req < cur otherwise: counter <= counter+1, state holds.
- If req varies among levels below cur during a hold, the count continues. The target is req sampled at the expiring edge.
- Any edge with req >= cur aborts the hold and clears the counter.
- Reset (resetN low, asynchronous assert): state = NORMAL, counter = 0, abnormalityWarning = 000 immediately.
- Reset mid-hold discards the hold.
- Release of reset is synchronized externally. The first edge after release evaluates normally.
- No illegal states: all 8 codes are valid.

Decomposition:
- Package healthcare_pkg holds:
  - the warning-code enum/localparams (NORMAL..FALL)
  - the nervous severity encodings (NERV_NONE/MILD/SEVERE/CRITICAL)
- Sub-module abnormality_priority_encoder: purely combinational, flags -> 3-bit requested level.
- The top level holds the FSM state register and the hold counter.

Test Plan:
- Reset: resetN=0 with all flags 1 -> abnormalityWarning=000 asynchronously. Release, then the next edge -> 111.
- Priority ladder, HOLD_CYCLES=1:
  - apply one flag at a time (temp, blood, pressure, nerv 01/10/11, fall), each held for one cycle;
  - required outputs after one edge: 001, 010, 011, 100, 101, 110, 111;
  - pressure+blood+temp with nerv 00 -> 011.
- Escalation/de-escalation, HOLD_CYCLES=4:
  - all flags 1, nerv 00 -> 111 after 1 edge;
  - then fall=0, temp=1, pressure=1, blood=1, nerv=11 -> stays 111 for 3 edges, becomes 110 on the 4th edge.
- Hold abort, HOLD_CYCLES=4:
  - from 111, drop to req 011 for 2 edges, then reassert fall -> output never leaves 111;
  - drop again -> full 4 edges are required.
- Mixed lower targets, HOLD_CYCLES=4, from 110: req sequence 001, 010, 011, 010 -> output 010 at the 4th edge.
- Reset mid-hold, HOLD_CYCLES=4: from 111 with req 000, assert resetN low after 2 edges -> 000 immediately; counter cleared.
